// File: rtl/hdmi_period_sequencer_if.sv
// rtl/hdmi_period_sequencer_if.sv - video timing in/out and period select bundle (SEQ_DVI_BYPASS_EN adds dvi_mode_i)
interface hdmi_period_sequencer_if #(
  parameter int DATA_W = 24
);
  // Raw timing stream from the video timing generator
  logic              de_i;
  logic              hsync_i;
  logic              vsync_i;
  logic [DATA_W-1:0] pix_i;
`ifdef SEQ_DVI_BYPASS_EN
  logic              dvi_mode_i;
`endif
  // Delayed stream plus period select towards the TMDS encoders
  logic              de_o;
  logic              hsync_o;
  logic              vsync_o;
  logic [DATA_W-1:0] pix_o;
  logic [1:0]        sel_o;
  logic [3:0]        ctl_o;
  logic              err_o;

`ifdef SEQ_DVI_BYPASS_EN
  modport master (
    output de_i, hsync_i, vsync_i, pix_i, dvi_mode_i,
    input  de_o, hsync_o, vsync_o, pix_o, sel_o, ctl_o, err_o
  );
  modport slave (
    input  de_i, hsync_i, vsync_i, pix_i, dvi_mode_i,
    output de_o, hsync_o, vsync_o, pix_o, sel_o, ctl_o, err_o
  );
`else
  modport master (
    output de_i, hsync_i, vsync_i, pix_i,
    input  de_o, hsync_o, vsync_o, pix_o, sel_o, ctl_o, err_o
  );
  modport slave (
    input  de_i, hsync_i, vsync_i, pix_i,
    output de_o, hsync_o, vsync_o, pix_o, sel_o, ctl_o, err_o
  );
`endif
endinterface

// File: rtl/hdmi_period_sequencer.sv
// rtl/hdmi_period_sequencer.sv - D-cycle timing delay with TMDS period select; SEQ_DVI_BYPASS_EN enables DVI bypass
module hdmi_period_sequencer #(
  parameter int DATA_W  = 24,
  parameter int PRE_LEN = 8,
  parameter int GB_LEN  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  hdmi_period_sequencer_if.slave bus
);

  // Lookahead equals the full preamble plus guard band ahead of video
  localparam int D  = PRE_LEN + GB_LEN;
  localparam int W  = DATA_W + 3;
  localparam int CW = $clog2(D + 1);
  localparam logic [CW-1:0] ONE   = CW'(1);
  localparam logic [CW-1:0] GB_C  = CW'(GB_LEN);
  localparam logic [CW-1:0] DM1_C = CW'(D - 1);
  localparam logic [CW-1:0] D_C   = CW'(D);

  typedef enum logic [1:0] {ST_CTRL, ST_PRE, ST_GB, ST_VID} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_m1;
  logic [W-1:0]  line_q [D];
  logic          de_prev_q;
  logic [CW-1:0] gap_q;
  logic          seen_vid_q;
  logic          err_q;
  logic          de_out, de_next, rise;
  logic [D-2:0]  ahead;
  logic          found;
  logic [CW-1:0] nk;
  logic [1:0]    sel_fsm, sel_out;
  logic          dvi_on;

`ifdef SEQ_DVI_BYPASS_EN
  assign dvi_on = bus.dvi_mode_i;
`else
  assign dvi_on = 1'b0;
`endif

  // de_next is what de_o will be next cycle; rise is gated so nothing leaks out during reset
  assign de_out  = line_q[D-1][W-1];
  assign de_next = line_q[D-2][W-1];
  assign rise    = bus.de_i & ~de_prev_q & rst_n;
  assign cnt_m1  = cnt_q - ONE;

  // Delay line: {de, hsync, vsync, pix} shifted through D registered stages
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < D; i++) line_q[i] <= '0;
    end else begin
      line_q[0] <= {bus.de_i, bus.hsync_i, bus.vsync_i, bus.pix_i};
      for (int i = 1; i < D; i++) line_q[i] <= line_q[i-1];
    end
  end

  // Distance from next output cycle to the nearest pending de (ahead[i] is de_o at distance i+1)
  always_comb begin
    ahead = '0;
    for (int i = 0; i < D - 2; i++) ahead[i] = line_q[D-3-i][W-1];
    ahead[D-2] = bus.de_i;
    found = 1'b0;
    nk    = '0;
    for (int i = D - 2; i >= 0; i--) begin
      if (ahead[i]) begin
        found = 1'b1;
        nk    = CW'(i + 1);
      end
    end
  end

  // Period FSM: cnt holds the distance k to the next de_o rising while in PRE/GB
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_fsm = 2'b00;
    unique case (state_q)
      ST_CTRL: begin
        // The rise seen on de_i now is exactly D cycles ahead of de_o
        if (rise) begin
          sel_fsm = 2'b01;
          cnt_d   = DM1_C;
          state_d = (DM1_C <= GB_C) ? ST_GB : ST_PRE;
        end
      end
      ST_PRE: begin
        sel_fsm = 2'b01;
        cnt_d   = cnt_m1;
        if (cnt_m1 <= GB_C) state_d = ST_GB;
      end
      ST_GB: begin
        sel_fsm = 2'b10;
        if (cnt_q == ONE) state_d = ST_VID;
        else              cnt_d   = cnt_m1;
      end
      ST_VID: begin
        sel_fsm = 2'b11;
        // Leaving video: a video run already in the line truncates PRE/GB
        if (!de_next) begin
          if (found) begin
            cnt_d   = nk;
            state_d = (nk <= GB_C) ? ST_GB : ST_PRE;
          end else begin
            state_d = ST_CTRL;
          end
        end
      end
      default: state_d = ST_CTRL;
    endcase
  end

  // FSM state, counter and de_i edge history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_CTRL;
      cnt_q     <= '0;
      de_prev_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      de_prev_q <= bus.de_i;
    end
  end

  // Sticky error when a blanking gap between two video runs on de_o is shorter than D
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_q      <= '0;
      seen_vid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (!de_out && de_next && seen_vid_q && (gap_q < DM1_C) && !dvi_on) err_q <= 1'b1;
      if (de_out)            gap_q <= '0;
      else if (gap_q != D_C) gap_q <= gap_q + ONE;
      seen_vid_q <= seen_vid_q | de_out;
    end
  end

  assign sel_out     = dvi_on ? {de_out, de_out} : sel_fsm;
  assign bus.sel_o   = sel_out;
  assign bus.ctl_o   = (sel_out == 2'b01) ? 4'b0001 : 4'b0000;
  assign bus.err_o   = err_q;
  assign bus.de_o    = de_out;
  assign bus.hsync_o = line_q[D-1][W-2];
  assign bus.vsync_o = line_q[D-1][W-3];
  assign bus.pix_o   = line_q[D-1][DATA_W-1:0];

endmodule

// File: tb/tb_hdmi_period_sequencer.sv
// tb/tb_hdmi_period_sequencer.sv - scoreboard bench for hdmi_period_sequencer
module tb_hdmi_period_sequencer;

  localparam int DATA_W  = 24;
  localparam int PRE_LEN = 8;
  localparam int GB_LEN  = 2;
  localparam int D       = 10;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hdmi_period_sequencer_if #(.DATA_W(DATA_W)) bus ();

  hdmi_period_sequencer #(
    .DATA_W (DATA_W),
    .PRE_LEN(PRE_LEN),
    .GB_LEN (GB_LEN)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic [23:0] pix;
  } in_t;

  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic [23:0] pix;
    logic [1:0]  sel;
    logic [3:0]  ctl;
    logic        err;
  } exp_t;

  in_t  hist[$];
  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  logic err_m;
  logic seen_m;
  int   low_m;
  logic [23:0] pcnt;

  task automatic model_clear();
    hist.delete();
    for (int i = 0; i < D; i++) hist.push_back('0);
    err_m  = 1'b0;
    seen_m = 1'b0;
    low_m  = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rst, input logic de, input logic hs, input logic vs,
                      input logic [23:0] pix, input logic dvi);
    in_t  cur;
    exp_t e;
    int   k;
    @(posedge clk);
    #1;
    rst_n       = rst;
    bus.de_i    = de;
    bus.hsync_i = hs;
    bus.vsync_i = vs;
    bus.pix_i   = pix;
`ifdef SEQ_DVI_BYPASS_EN
    bus.dvi_mode_i = dvi;
`endif
    e = '0;
    if (!rst) begin
      model_clear();
    end else begin
      cur.de  = de;
      cur.hs  = hs;
      cur.vs  = vs;
      cur.pix = pix;
      hist.push_back(cur);
      e.de  = hist[0].de;
      e.hs  = hist[0].hs;
      e.vs  = hist[0].vs;
      e.pix = hist[0].pix;
      k = 0;
      for (int j = D; j >= 1; j--) if (hist[j].de) k = j;
      if (hist[0].de)       e.sel = 2'b11;
      else if (dvi)         e.sel = 2'b00;
      else if (k == 0)      e.sel = 2'b00;
      else if (k <= GB_LEN) e.sel = 2'b10;
      else                  e.sel = 2'b01;
      e.ctl = (e.sel == 2'b01) ? 4'b0001 : 4'b0000;
      e.err = err_m;
      if (!dvi && !hist[0].de && hist[1].de && seen_m && (low_m + 1 <= D - 1)) err_m = 1'b1;
      if (hist[0].de) begin
        low_m  = 0;
        seen_m = 1'b1;
      end else begin
        low_m++;
      end
      void'(hist.pop_front());
    end
    exp_q.push_back(e);
    @(negedge clk);
    e = exp_q.pop_front();
    check("de_o",    32'(bus.de_o),    32'(e.de));
    check("hsync_o", 32'(bus.hsync_o), 32'(e.hs));
    check("vsync_o", 32'(bus.vsync_o), 32'(e.vs));
    check("pix_o",   32'(bus.pix_o),   32'(e.pix));
    check("sel_o",   32'(bus.sel_o),   32'(e.sel));
    check("ctl_o",   32'(bus.ctl_o),   32'(e.ctl));
    check("err_o",   32'(bus.err_o),   32'(e.err));
  endtask

  task automatic run(input int n, input logic de, input logic dvi);
    repeat (n) begin
      step(1'b1, de, 1'b0, 1'b0, pcnt, dvi);
      pcnt = pcnt + 24'd1;
    end
  endtask

  initial begin
    logic lvl;
    rst_n       = 1'b0;
    bus.de_i    = 1'b0;
    bus.hsync_i = 1'b0;
    bus.vsync_i = 1'b0;
    bus.pix_i   = '0;
`ifdef SEQ_DVI_BYPASS_EN
    bus.dvi_mode_i = 1'b0;
`endif
    pcnt = 24'd0;
    model_clear();

    // Reset with random inputs, then idle after release
    repeat (4) step(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 24'($urandom), 1'b0);
    run(5, 1'b0, 1'b0);

    // Single line
    run(20, 1'b0, 1'b0);
    run(16, 1'b1, 1'b0);
    run(20, 1'b0, 1'b0);

    // Short gap between two video runs
    run(4, 1'b1, 1'b0);
    run(6, 1'b0, 1'b0);
    run(4, 1'b1, 1'b0);
    run(15, 1'b0, 1'b0);

    // Reset mid-preamble, release with de_i held high
    run(15, 1'b0, 1'b0);
    run(4, 1'b1, 1'b0);
    repeat (2) step(1'b0, 1'b1, 1'($urandom), 1'($urandom), 24'($urandom), 1'b0);
    run(20, 1'b1, 1'b0);
    run(15, 1'b0, 1'b0);

    // Sync pass-through during blanking
    repeat (20) step(1'b1, 1'b0, 1'($urandom), 1'($urandom), 24'($urandom), 1'b0);
    run(12, 1'b0, 1'b0);

    // Random runs including single-cycle pulses and truncated gaps
    lvl = 1'b0;
    for (int r = 0; r < 40; r++) begin
      run($urandom_range(1, 14), lvl, 1'b0);
      lvl = ~lvl;
    end
    run(15, 1'b0, 1'b0);

`ifdef SEQ_DVI_BYPASS_EN
    // DVI bypass: no preamble/guard band, error never set
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, 24'd0, 1'b1);
    run(20, 1'b0, 1'b1);
    run(16, 1'b1, 1'b1);
    run(20, 1'b0, 1'b1);
    run(4, 1'b1, 1'b1);
    run(6, 1'b0, 1'b1);
    run(4, 1'b1, 1'b1);
    run(15, 1'b0, 1'b1);
    run(16, 1'b1, 1'b0);
    run(15, 1'b0, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
